alu_share_ctrl: RTL and testbench

- Sequencer and arbiter that shares the single combinational 32-bit ALU between two requesters: port 0 is the main datapath and port 1 is the branch/compare unit.
- Per transaction, the block:
  - arbitrates between the two requesters;
  - registers the operands and the 6-bit ALU control code;
  - drives the ALU for one execute cycle and captures out/zero/overflow;
  - returns the result to the winning requester over a valid/ready handshake.
- It also flags control codes the ALU does not implement.

---
 rtl/alu_share_ctrl_if.sv | 54 +++++
 rtl/alu_share_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// Bundle of the request, response and ALU-side signals of the shared-ALU controller.
// The slave modport is the controller's view; master is the environment's view.
interface alu_share_ctrl_if #(
  parameter int W = 32
);
  logic         req_valid0;
  logic         req_valid1;
  logic         req_ready0;
  logic         req_ready1;
  logic [5:0]   req_ctrl0;
  logic [5:0]   req_ctrl1;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_b0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b1;

  logic         rsp_valid0;
  logic         rsp_valid1;
  logic         rsp_ready0;
  logic         rsp_ready1;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic         rsp_ovf;
  logic         rsp_err;

  logic [5:0]   alu_ctrl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         alu_ovf;

  logic         busy;

  modport slave (
    input  req_valid0, req_valid1, req_ctrl0, req_ctrl1,
           req_a0, req_b0, req_a1, req_b1,
           rsp_ready0, rsp_ready1,
           alu_out, alu_zero, alu_ovf,
    output req_ready0, req_ready1,
           rsp_valid0, rsp_valid1, rsp_data, rsp_zero, rsp_ovf, rsp_err,
           alu_ctrl, alu_a, alu_b, busy
  );

  modport master (
    output req_valid0, req_valid1, req_ctrl0, req_ctrl1,
           req_a0, req_b0, req_a1, req_b1,
           rsp_ready0, rsp_ready1,
           alu_out, alu_zero, alu_ovf,
    input  req_ready0, req_ready1,
           rsp_valid0, rsp_valid1, rsp_data, rsp_zero, rsp_ovf, rsp_err,
           alu_ctrl, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one combinational ALU: accept, execute for one
// cycle, then hold the captured result until the winning port takes it.
module alu_share_ctrl #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         grant_q, grant_d;
  logic [5:0]   ctrl_q, ctrl_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] out_q, out_d;
  logic         zero_q, zero_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;

  logic sel;
  logic ready0;
  logic ready1;
  logic accept;
  logic unsupported;
  logic rsp_taken;

  // On a tie round-robin favours the port that did not win last time.
  always_comb begin
    sel = 1'b0;
    if (bus.req_valid0 && bus.req_valid1) begin
      sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else if (bus.req_valid1) begin
      sel = 1'b1;
    end
  end

  // Gated by rst_n so no ready can escape while the block is held in reset.
  assign ready0 = rst_n && (state_q == IDLE) && bus.req_valid0 && !sel;
  assign ready1 = rst_n && (state_q == IDLE) && bus.req_valid1 && sel;
  assign accept = ready0 || ready1;

  always_comb begin
    case (ctrl_q)
      6'd1, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14,
      6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42: unsupported = 1'b0;
      default:                                  unsupported = 1'b1;
    endcase
  end

  assign rsp_taken = grant_q ? bus.rsp_ready1 : bus.rsp_ready0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    out_d        = out_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ctrl_d       = sel ? bus.req_ctrl1 : bus.req_ctrl0;
          a_d          = sel ? bus.req_a1    : bus.req_a0;
          b_d          = sel ? bus.req_b1    : bus.req_b0;
          grant_d      = sel;
          last_grant_d = sel;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        out_d   = bus.alu_out;
        zero_d  = bus.alu_zero;
        ovf_d   = bus.alu_ovf;
        err_d   = unsupported;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_taken) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      out_q        <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_q        <= out_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready0 = ready0;
  assign bus.req_ready1 = ready1;
  assign bus.rsp_valid0 = (state_q == RESP) && !grant_q;
  assign bus.rsp_valid1 = (state_q == RESP) && grant_q;
  assign bus.rsp_data   = out_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.rsp_err    = err_q;
  // Only the execute cycle presents a real opcode; operands stay on the bus.
  assign bus.alu_ctrl   = (state_q == EXEC) ? ctrl_q : 6'd0;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.busy       = (state_q == EXEC) || (state_q == RESP);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: a round-robin instance is fully checked, and a
// fixed-priority instance sharing the same request stimulus is watched during ties.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid0, req_valid1;
  logic [5:0]  req_ctrl0, req_ctrl1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_ready0, rsp_ready1;

  alu_share_ctrl_if #(.W(32)) bus0 ();
  alu_share_ctrl_if #(.W(32)) bus1 ();

  alu_share_ctrl #(.FIXED_PRIO(1'b0), .W(32)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  alu_share_ctrl #(.FIXED_PRIO(1'b1), .W(32)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Reference ALU returning {zero, ovf, out}
  function automatic logic [33:0] alu_model(input logic [5:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = 32'd0;
    v = 1'b0;
    case (c)
      6'd1:          r = {31'd0, a[31]};
      6'd4, 6'd5,
      6'd34:         r = a - b;
      6'd8, 6'd32: begin
        r = a + b;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      6'd9:          r = {b[15:0], 16'd0};
      6'd10, 6'd42:  r = {31'd0, $signed(a) < $signed(b)};
      6'd12, 6'd36:  r = a & b;
      6'd13, 6'd37:  r = a | b;
      6'd14:         r = a ^ b;
      6'd39:         r = ~(a | b);
      default:       r = 32'd0;
    endcase
    return {(r == 32'd0), v, r};
  endfunction

  assign bus0.req_valid0 = req_valid0;
  assign bus0.req_valid1 = req_valid1;
  assign bus0.req_ctrl0  = req_ctrl0;
  assign bus0.req_ctrl1  = req_ctrl1;
  assign bus0.req_a0     = req_a0;
  assign bus0.req_b0     = req_b0;
  assign bus0.req_a1     = req_a1;
  assign bus0.req_b1     = req_b1;
  assign bus0.rsp_ready0 = rsp_ready0;
  assign bus0.rsp_ready1 = rsp_ready1;
  assign {bus0.alu_zero, bus0.alu_ovf, bus0.alu_out} =
         alu_model(bus0.alu_ctrl, bus0.alu_a, bus0.alu_b);

  assign bus1.req_valid0 = req_valid0;
  assign bus1.req_valid1 = req_valid1;
  assign bus1.req_ctrl0  = req_ctrl0;
  assign bus1.req_ctrl1  = req_ctrl1;
  assign bus1.req_a0     = req_a0;
  assign bus1.req_b0     = req_b0;
  assign bus1.req_a1     = req_a1;
  assign bus1.req_b1     = req_b1;
  assign bus1.rsp_ready0 = 1'b1;
  assign bus1.rsp_ready1 = 1'b1;
  assign {bus1.alu_zero, bus1.alu_ovf, bus1.alu_out} =
         alu_model(bus1.alu_ctrl, bus1.alu_a, bus1.alu_b);

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        zero;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   check_count = 0;
  int   err_count   = 0;
  logic fp_window   = 1'b0;
  int   fp_ready1_cnt = 0;
  int   fp_acc0_cnt   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input int port, input logic [31:0] data, input logic zero,
                         input logic ovf, input logic err);
    exp_t e;
    e.port = port;
    e.data = data;
    e.zero = zero;
    e.ovf  = ovf;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic popCheck(input int port);
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput("sb_unexpected", 1, 0);
    end else begin
      e = sb_q.pop_front();
      checkOutput("sb_port", port, e.port);
      checkOutput("sb_data", bus0.rsp_data, e.data);
      checkOutput("sb_zero", bus0.rsp_zero, e.zero);
      checkOutput("sb_ovf",  bus0.rsp_ovf,  e.ovf);
      checkOutput("sb_err",  bus0.rsp_err,  e.err);
    end
  endtask

  // Response monitor: a completed response handshake pops one expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.rsp_valid0 && bus0.rsp_valid1) checkOutput("rsp_both_valid", 1, 0);
      if (bus0.rsp_valid0 && rsp_ready0)      popCheck(0);
      else if (bus0.rsp_valid1 && rsp_ready1) popCheck(1);
    end
  end

  // Observes the fixed-priority instance while both ports compete
  always @(negedge clk) begin
    if (fp_window) begin
      if (bus1.req_ready1) fp_ready1_cnt++;
      if (bus1.req_ready0 && req_valid0) fp_acc0_cnt++;
    end
  end

  // Single request on one port, held until accepted
  task automatic applyStimulus(input int port, input logic [5:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_data,
                               input logic exp_zero, input logic exp_ovf, input logic exp_err);
    int waited;
    pushExp(port, exp_data, exp_zero, exp_ovf, exp_err);
    @(posedge clk);
    #1;
    if (port == 0) begin
      req_ctrl0 = ctrl; req_a0 = a; req_b0 = b; req_valid0 = 1'b1;
    end else begin
      req_ctrl1 = ctrl; req_a1 = a; req_b1 = b; req_valid1 = 1'b1;
    end
    waited = 0;
    while (waited < 100) begin
      @(negedge clk);
      if ((port == 0) ? bus0.req_ready0 : bus0.req_ready1) break;
      waited++;
    end
    if (waited >= 100) checkOutput("req_accept_timeout", waited, 0);
    @(posedge clk);
    #1;
    req_valid0 = (port == 0) ? 1'b0 : req_valid0;
    req_valid1 = (port == 1) ? 1'b0 : req_valid1;
  endtask

  // Both ports valid until n requests have been accepted
  task automatic runTie(input int n);
    int cnt;
    cnt = 0;
    req_valid0 = 1'b1;
    req_valid1 = 1'b1;
    for (int cyc = 0; cyc < 200 && cnt < n; cyc++) begin
      @(negedge clk);
      if ((bus0.req_ready0 && req_valid0) || (bus0.req_ready1 && req_valid1)) cnt++;
    end
    if (cnt < n) checkOutput("tie_accept_timeout", cnt, n);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checkOutput("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic setTiePayload();
    req_ctrl0 = 6'd36; req_a0 = 32'h0000_F0F0; req_b0 = 32'h0000_FF00;
    req_ctrl1 = 6'd4;  req_a1 = 32'd3;         req_b1 = 32'd3;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_ctrl0  = 6'd0; req_ctrl1  = 6'd0;
    req_a0     = '0;   req_b0     = '0;
    req_a1     = '0;   req_b1     = '0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy",       bus0.busy,       0);
    checkOutput("rst_rsp_valid0", bus0.rsp_valid0, 0);
    checkOutput("rst_rsp_data",   bus0.rsp_data,   0);
    checkOutput("rst_alu_ctrl",   bus0.alu_ctrl,   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Add on port 0 with cycle-by-cycle timing
    pushExp(0, 32'd12, 1'b0, 1'b0, 1'b0);
    req_ctrl0 = 6'd32; req_a0 = 32'd5; req_b0 = 32'd7; req_valid0 = 1'b1;
    @(negedge clk);
    checkOutput("t1_ready0", bus0.req_ready0, 1);
    checkOutput("t1_ready1", bus0.req_ready1, 0);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    checkOutput("t1_exec_busy",   bus0.busy,       1);
    checkOutput("t1_exec_ctrl",   bus0.alu_ctrl,   32);
    checkOutput("t1_exec_alu_a",  bus0.alu_a,      5);
    checkOutput("t1_exec_valid0", bus0.rsp_valid0, 0);
    @(negedge clk);
    checkOutput("t1_resp_valid0", bus0.rsp_valid0, 1);
    checkOutput("t1_resp_data",   bus0.rsp_data,   12);
    checkOutput("t1_resp_alu_ctrl", bus0.alu_ctrl, 0);
    @(negedge clk);
    checkOutput("t1_idle_busy",   bus0.busy,       0);
    checkOutput("t1_idle_valid0", bus0.rsp_valid0, 0);

    // Unsupported code, then a valid subtract on port 1
    applyStimulus(1, 6'd63, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, 6'd34, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0);
    waitDrain();

    // Ties: round-robin alternates starting at port 0, fixed priority never readies port 1
    @(posedge clk);
    #1;
    setTiePayload();
    pushExp(0, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    pushExp(1, 32'd0,         1'b1, 1'b0, 1'b0);
    pushExp(0, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    pushExp(1, 32'd0,         1'b1, 1'b0, 1'b0);
    fp_window = 1'b1;
    runTie(4);
    waitDrain();
    fp_window = 1'b0;
    checkOutput("fp_ready1_count", fp_ready1_cnt, 0);
    checkOutput("fp_p0_accepted",  (fp_acc0_cnt >= 2), 1);

    // Backpressure on port 0 while port 1 waits
    @(posedge clk);
    #1;
    rsp_ready0 = 1'b0;
    applyStimulus(0, 6'd9, 32'd0, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0);
    pushExp(1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    req_ctrl1 = 6'd37; req_a1 = 32'h0000_00F0; req_b1 = 32'h0000_000F; req_valid1 = 1'b1;
    @(negedge clk);
    checkOutput("bp_exec_ready1", bus0.req_ready1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid0", bus0.rsp_valid0, 1);
      checkOutput("bp_data",   bus0.rsp_data,   32'h1234_0000);
      checkOutput("bp_busy",   bus0.busy,       1);
      checkOutput("bp_ready1", bus0.req_ready1, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready0 = 1'b1;
    begin
      int waited;
      waited = 0;
      while (waited < 50) begin
        @(negedge clk);
        if (bus0.req_ready1) break;
        waited++;
      end
      if (waited >= 50) checkOutput("bp_p1_accept_timeout", waited, 0);
    end
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    waitDrain();

    // Reset in the middle of execution abandons the transaction
    @(posedge clk);
    #1;
    req_ctrl0 = 6'd32; req_a0 = 32'd1; req_b0 = 32'd2; req_valid0 = 1'b1;
    @(negedge clk);
    checkOutput("rt_ready0", bus0.req_ready0, 1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    #2;
    rst_n = 1'b0;
    setTiePayload();
    req_valid0 = 1'b1;
    req_valid1 = 1'b1;
    #1;
    checkOutput("rt_busy",     bus0.busy,       0);
    checkOutput("rt_alu_ctrl", bus0.alu_ctrl,   0);
    checkOutput("rt_alu_a",    bus0.alu_a,      0);
    checkOutput("rt_alu_b",    bus0.alu_b,      0);
    checkOutput("rt_valid0",   bus0.rsp_valid0, 0);
    checkOutput("rt_data",     bus0.rsp_data,   0);
    checkOutput("rt_ready0",   bus0.req_ready0, 0);
    checkOutput("rt_ready1",   bus0.req_ready1, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rt_release_valid0", bus0.rsp_valid0, 0);
    pushExp(0, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    pushExp(1, 32'd0,         1'b1, 1'b0, 1'b0);
    runTie(2);
    waitDrain();

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
